sram_line_ctrl: RTL

Responder side of the cache↔SRAM interface. Accepts line-fill and write-through requests from the data cache and runs them on the off-chip 256K×16 asynchronous SRAM. Reads collect four halfwords into one 64-bit cache line. Writes store one 32-bit word as two halfwords. While a request is in service the block holds `pause` high, which stalls the pipeline.

---
 rtl/sram_pkg.sv | 52 +++++
 rtl/sram_line_ctrl_if.sv | 23 ++
 rtl/sram_phy_io.sv | 50 +++++
 rtl/sram_line_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the cache-side SRAM line controller.
// Strobe bundle and per-cycle PHY command helpers live here.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int LINE_HW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DONE,
        S_TURN
    } state_t;

    typedef struct packed {
        logic ce_n;
        logic we_n;
        logic oe_n;
        logic ub_n;
        logic lb_n;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam strobe_t STROBE_RD   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    typedef struct packed {
        strobe_t              stb;
        logic                 addr_en;
        logic [SRAM_AW-1:0]   addr;
        logic                 drive;
        logic [SRAM_DW-1:0]   dout;
    } phy_cmd_t;

    function automatic phy_cmd_t idle_cmd();
        idle_cmd = '{STROBE_IDLE, 1'b0, '0, 1'b0, '0};
    endfunction

    function automatic phy_cmd_t rd_cmd(input logic [SRAM_AW-1:0] a);
        rd_cmd = '{STROBE_RD, 1'b1, a, 1'b0, '0};
    endfunction

    function automatic phy_cmd_t wr_cmd(input logic [SRAM_AW-1:0] a,
                                        input logic [SRAM_DW-1:0] d,
                                        input logic we_n);
        strobe_t s;
        s = '{1'b0, we_n, 1'b1, 1'b0, 1'b0};
        wr_cmd = '{s, 1'b1, a, 1'b1, d};
    endfunction

endpackage

// File: rtl/sram_line_ctrl_if.sv
// Cache-side request/response bundle of the SRAM line controller.
// The cache is the master; the controller is the slave.
interface sram_line_ctrl_if;

    logic        rd_req;
    logic        wr_req;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        pause;
    logic [63:0] line_data;
    logic        line_ready;

    modport master (
        output rd_req, wr_req, address, wr_data,
        input  pause, line_data, line_ready
    );

    modport slave (
        input  rd_req, wr_req, address, wr_data,
        output pause, line_data, line_ready
    );

endinterface

// File: rtl/sram_phy_io.sv
// Pin-level register stage: strobes, address, dq tri-state and capture.
// Every SRAM pin is driven straight from a flop.
module sram_phy_io
    import sram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  phy_cmd_t           cmd,
    input  logic               cap_en,
    input  logic [1:0]         cap_idx,
    output logic [63:0]        line_data,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    strobe_t            stb;
    logic               drive;
    logic [SRAM_DW-1:0] dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            stb       <= STROBE_IDLE;
            sram_addr <= '0;
            drive     <= 1'b0;
            dout      <= '0;
            line_data <= '0;
        end else begin
            stb   <= cmd.stb;
            drive <= cmd.drive;
            dout  <= cmd.dout;
            if (cmd.addr_en)
                sram_addr <= cmd.addr;
            if (cap_en)
                line_data[{cap_idx, 4'b0000} +: SRAM_DW] <= sram_dq;
        end
    end

    assign sram_dq   = drive ? dout : 'z;
    assign sram_ce_n = stb.ce_n;
    assign sram_we_n = stb.we_n;
    assign sram_oe_n = stb.oe_n;
    assign sram_ub_n = stb.ub_n;
    assign sram_lb_n = stb.lb_n;

endmodule

// File: rtl/sram_line_ctrl.sv
// Cache line-fill / write-through responder for a 256Kx16 async SRAM.
// Define SRAM_TURNAROUND_EN to insert a bus turnaround before write->read.
module sram_line_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_line_ctrl_if.slave    bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

`ifdef SRAM_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    localparam logic [2:0] W = 3'(WAIT_CYCLES);

    state_t             state;
    logic [1:0]         ph;
    logic [2:0]         wc;
    logic [SRAM_AW-1:0] base;
    logic [31:0]        wdata;
    logic               is_wr;
    logic               after_wr;
    logic               line_ready_q;

    logic               adv;
    logic               turn_req;
    logic [1:0]         ph_n;
    logic [2:0]         wc_n;
    phy_cmd_t           cmd;
    logic               cap_en;

    assign adv      = (wc == W);
    assign turn_req = TURN_EN && after_wr;
    assign ph_n     = ph + 2'd1;
    assign wc_n     = wc + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ph           <= '0;
            wc           <= '0;
            base         <= '0;
            wdata        <= '0;
            is_wr        <= 1'b0;
            after_wr     <= 1'b0;
            line_ready_q <= 1'b0;
        end else begin
            line_ready_q <= 1'b0;
            after_wr     <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    ph <= '0;
                    wc <= '0;
                    if (bus.wr_req) begin
                        state <= S_WR;
                        is_wr <= 1'b1;
                        base  <= {bus.address[18:2], 1'b0};
                        wdata <= bus.wr_data;
                    end else if (bus.rd_req) begin
                        state <= turn_req ? S_TURN : S_RD;
                        is_wr <= 1'b0;
                        base  <= {bus.address[18:3], 2'b00};
                    end
                end
                S_TURN: state <= S_RD;
                S_WR, S_RD: begin
                    if (adv) begin
                        wc <= '0;
                        ph <= ph_n;
                        if ((state == S_WR && ph == 2'd1) || ph == 2'd3) begin
                            state        <= S_DONE;
                            line_ready_q <= (state == S_RD);
                        end
                    end else begin
                        wc <= wc_n;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    after_wr <= is_wr;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pins for the next cycle; the PHY registers them.
    always_comb begin
        cmd    = idle_cmd();
        cap_en = (state == S_RD) && adv;
        unique case (state)
            S_IDLE: begin
                if (bus.wr_req)
                    cmd = wr_cmd({bus.address[18:2], 1'b0},
                                 bus.wr_data[15:0], 1'b0);
                else if (bus.rd_req && !turn_req)
                    cmd = rd_cmd({bus.address[18:3], 2'b00});
            end
            S_TURN: cmd = rd_cmd(base);
            S_WR: begin
                if (!adv)
                    cmd = wr_cmd(base + SRAM_AW'(ph),
                                 ph[0] ? wdata[31:16] : wdata[15:0],
                                 wc_n == W);
                else if (ph == 2'd0)
                    cmd = wr_cmd(base + SRAM_AW'(1), wdata[31:16], 1'b0);
            end
            S_RD: begin
                if (!adv)
                    cmd = rd_cmd(base + SRAM_AW'(ph));
                else if (ph != 2'd3)
                    cmd = rd_cmd(base + SRAM_AW'(ph_n));
            end
            default: cmd = idle_cmd();
        endcase
    end

    assign bus.pause = (bus.rd_req | bus.wr_req) && state != S_DONE && !rst;
    assign bus.line_ready = line_ready_q;

    sram_phy_io u_phy (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .cap_en    (cap_en),
        .cap_idx   (ph),
        .line_data (bus.line_data),
        .sram_addr (sram_addr),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

endmodule
